// File: rtl/video_pkg.sv
// Shared definitions for the video SRAM arbiter: slot-owner encodings and SRAM word geometry.
package video_pkg;

  localparam int unsigned SramDataWidth = 32;
  localparam int unsigned SramMaskWidth = 4;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotVga,
    SlotCpu,
    SlotCpuAck
  } slot_e;

endpackage

// File: rtl/video_memory_arbiter_if.sv
// Bundle of VGA fetch, Wishbone slave and SRAM macro signals around the video memory arbiter.
interface video_memory_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  import video_pkg::*;

  logic                     vga_req;
  logic [ADDR_WIDTH-1:0]    vga_addr;
  logic                     vga_gnt;
  logic                     vga_rvalid;
  logic [SramDataWidth-1:0] vga_rdata;

  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic                     wb_we_i;
  logic [SramMaskWidth-1:0] wb_sel_i;
  logic [ADDR_WIDTH-1:0]    wb_adr_i;
  logic [SramDataWidth-1:0] wb_dat_i;
  logic                     wb_ack_o;
  logic [SramDataWidth-1:0] wb_dat_o;

  logic                     sram_csb;
  logic                     sram_web;
  logic [SramMaskWidth-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]    sram_addr;
  logic [SramDataWidth-1:0] sram_din;
  logic [SramDataWidth-1:0] sram_dout;

  // Arbiter side.
  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  // Requesters and SRAM macro side.
  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );

endinterface

// File: rtl/video_arb_starve_counter.sv
// Saturating count of VGA grants taken while a CPU access waits; built only with
// VIDEO_ARB_STARVE_GUARD_EN.
module video_arb_starve_counter #(
  parameter int unsigned BurstMax = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CntWidth = $clog2(BurstMax + 1);

  logic [CntWidth-1:0] cnt_q;

  assign at_max = (cnt_q == CntWidth'(BurstMax));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/video_memory_arbiter.sv
// Single-port video SRAM arbiter: VGA fetch has priority over Wishbone CPU access.
// Defining VIDEO_ARB_STARVE_GUARD_EN bounds CPU wait to VGA_BURST_MAX VGA grants.
module video_memory_arbiter
  import video_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned VGA_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_memory_arbiter_if.slave bus
);

  slot_e                 state_q;
  slot_e                 slot;
  logic                  cpu_elig;
  logic                  force_cpu;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic                  rsp_valid_q;
  logic                  rsp_cpu_q;
  logic                  rsp_we_q;

  // A held classic-cycle strobe must not be granted again while its ack is out.
  assign cpu_elig = bus.wb_cyc_i & bus.wb_stb_i & (state_q != SlotCpuAck);

`ifdef VIDEO_ARB_STARVE_GUARD_EN
  logic guard_at_max;

  video_arb_starve_counter #(
    .BurstMax(VGA_BURST_MAX)
  ) u_starve_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((slot == SlotVga) & cpu_elig),
    .clr   ((slot == SlotCpu) | ~cpu_elig),
    .at_max(guard_at_max)
  );

  assign force_cpu = cpu_elig & guard_at_max;
`else
  logic unused_burst_max;
  assign unused_burst_max = ^VGA_BURST_MAX;
  assign force_cpu        = 1'b0;
`endif

  // Grants are gated by reset so the SRAM is deselected the moment reset asserts.
  always_comb begin
    slot = SlotIdle;
    if (rst_n) begin
      if (force_cpu) begin
        slot = SlotCpu;
      end else if (bus.vga_req) begin
        slot = SlotVga;
      end else if (cpu_elig) begin
        slot = SlotCpu;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SlotIdle;
      rsp_valid_q <= 1'b0;
      rsp_cpu_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      case (slot)
        SlotCpu: state_q <= SlotCpuAck;
        SlotVga: state_q <= SlotVga;
        default: state_q <= SlotIdle;
      endcase
      rsp_valid_q <= (slot != SlotIdle);
      rsp_cpu_q   <= (slot == SlotCpu);
      rsp_we_q    <= (slot == SlotCpu) & bus.wb_we_i;
    end
  end

  always_comb begin
    slot_addr      = '0;
    bus.vga_gnt    = 1'b0;
    bus.sram_csb   = 1'b1;
    // Write enable idles low once running; it only reads high while held in reset.
    bus.sram_web   = ~rst_n;
    bus.sram_wmask = '0;
    bus.sram_din   = '0;
    case (slot)
      SlotVga: begin
        bus.vga_gnt  = 1'b1;
        bus.sram_csb = 1'b0;
        bus.sram_web = 1'b1;
        slot_addr    = bus.vga_addr;
      end
      SlotCpu: begin
        bus.sram_csb   = 1'b0;
        bus.sram_web   = ~bus.wb_we_i;
        bus.sram_wmask = bus.wb_we_i ? bus.wb_sel_i : '0;
        bus.sram_din   = bus.wb_dat_i;
        slot_addr      = bus.wb_adr_i;
      end
      default: ;
    endcase
    bus.sram_addr = slot_addr;
  end

  always_comb begin
    bus.vga_rvalid = rsp_valid_q & ~rsp_cpu_q;
    bus.wb_ack_o   = rsp_valid_q & rsp_cpu_q;
    bus.vga_rdata  = bus.vga_rvalid ? bus.sram_dout : '0;
    bus.wb_dat_o   = (bus.wb_ack_o & ~rsp_we_q) ? bus.sram_dout : '0;
  end

endmodule

// File: tb/tb_video_memory_arbiter.sv
// Directed bench for video_memory_arbiter with an SRAM model and read-data scoreboards.
module tb_video_memory_arbiter;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] vga_q[$];
  logic [31:0] mem[512];

  video_memory_arbiter_if #(.ADDR_WIDTH(9)) bus ();

  video_memory_arbiter #(
    .ADDR_WIDTH   (9),
    .VGA_BURST_MAX(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] pat(input logic [8:0] a);
    return 32'hC0DE_0000 ^ {7'h0, a, 7'h0, a};
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(9'(i));
  end

  // SRAM macro model: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_wmask[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
        end
      end else begin
        bus.sram_dout <= mem[bus.sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboards when the DUT returns data.
  always @(posedge clk) begin
    #1;
    if (bus.wb_ack_o) begin
      if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'(bus.wb_ack_o), 32'h0);
      else chk("cpu_rdata", bus.wb_dat_o, cpu_q.pop_front());
    end
    if (bus.vga_rvalid) begin
      if (vga_q.size() == 0) chk("vga_rvalid_unexpected", 32'(bus.vga_rvalid), 32'h0);
      else chk("vga_rdata", bus.vga_rdata, vga_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic cpu_slot();
    return rst_n && !bus.sram_csb && !bus.vga_gnt;
  endfunction

  task automatic cpu_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [8:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] exp_rd, input string tag);
    int waited = 0;
    step();
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    cpu_q.push_back(we ? 32'h0 : exp_rd);
    #1;
    while (!cpu_slot() && waited < 20) begin
      step();
      #1;
      waited++;
    end
    chk({tag, "_gnt"}, 32'(cpu_slot()), 32'h1);
    chk({tag, "_web"}, 32'(bus.sram_web), 32'(!we));
    chk({tag, "_wmask"}, 32'(bus.sram_wmask), 32'(we ? sel : 4'h0));
    chk({tag, "_addr"}, 32'(bus.sram_addr), 32'(adr));
    chk({tag, "_din"}, bus.sram_din, dat);
    step();
    #1;
    chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'h1);
    chk({tag, "_no_regrant"}, 32'(bus.sram_csb), 32'h1);
    cpu_idle();
  endtask

  int cpu_at;
  int vga_before;

  initial begin
    rst_n        = 1'b0;
    bus.vga_req  = 1'b0;
    bus.vga_addr = '0;
    bus.wb_sel_i = '0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    cpu_idle();

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      step();
      bus.vga_req  = 1'($urandom);
      bus.vga_addr = 9'($urandom);
      bus.wb_cyc_i = 1'($urandom);
      bus.wb_stb_i = 1'($urandom);
      bus.wb_we_i  = 1'($urandom);
      bus.wb_sel_i = 4'($urandom);
      bus.wb_adr_i = 9'($urandom);
      bus.wb_dat_i = $urandom;
      #1;
      chk("rst_csb", 32'(bus.sram_csb), 32'h1);
      chk("rst_web", 32'(bus.sram_web), 32'h1);
      chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
      chk("rst_rvalid", 32'(bus.vga_rvalid), 32'h0);
      chk("rst_gnt", 32'(bus.vga_gnt), 32'h0);
      chk("rst_wmask", 32'(bus.sram_wmask), 32'h0);
      chk("rst_addr", 32'(bus.sram_addr), 32'h0);
      chk("rst_din", bus.sram_din, 32'h0);
      chk("rst_wb_dat", bus.wb_dat_o, 32'h0);
      chk("rst_vga_rdata", bus.vga_rdata, 32'h0);
    end
    step();
    bus.vga_req = 1'b0;
    cpu_idle();
    rst_n = 1'b1;
    #1;
    chk("idle_csb", 32'(bus.sram_csb), 32'h1);

    // CPU write then read.
    cpu_access(1'b1, 9'd5, 4'hF, 32'hDEAD_BEEF, 32'h0, "wr5");
    cpu_access(1'b0, 9'd5, 4'hF, 32'h0, 32'hDEAD_BEEF, "rd5");

    // Byte-lane write.
    cpu_access(1'b1, 9'd7, 4'hF, 32'h1122_3344, 32'h0, "wr7");
    cpu_access(1'b1, 9'd7, 4'h2, 32'h0000_AA00, 32'h0, "wr7_byte");
    cpu_access(1'b0, 9'd7, 4'hF, 32'h0, 32'h1122_AA44, "rd7");

    // Single VGA fetch.
    step();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 9'h21;
    #1;
    chk("vga_gnt", 32'(bus.vga_gnt), 32'h1);
    chk("vga_sram_addr", 32'(bus.sram_addr), 32'h21);
    if (bus.vga_gnt) vga_q.push_back(pat(9'h21));
    step();
    bus.vga_req = 1'b0;
    #1;
    chk("vga_rvalid", 32'(bus.vga_rvalid), 32'h1);
    chk("vga_gnt_drop", 32'(bus.vga_gnt), 32'h0);

    // Contention: VGA wins, CPU next cycle.
    step();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 9'h30;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 9'd5;
    bus.wb_dat_i = 32'h0;
    cpu_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("cont_vga_gnt", 32'(bus.vga_gnt), 32'h1);
    chk("cont_vga_addr", 32'(bus.sram_addr), 32'h30);
    chk("cont_vga_web", 32'(bus.sram_web), 32'h1);
    if (bus.vga_gnt) vga_q.push_back(pat(9'h30));
    step();
    bus.vga_req = 1'b0;
    #1;
    chk("cont_cpu_gnt", 32'(cpu_slot()), 32'h1);
    chk("cont_cpu_addr", 32'(bus.sram_addr), 32'h5);
    chk("cont_vga_rvalid", 32'(bus.vga_rvalid), 32'h1);
    step();
    #1;
    chk("cont_ack", 32'(bus.wb_ack_o), 32'h1);
    chk("cont_rvalid_done", 32'(bus.vga_rvalid), 32'h0);
    cpu_idle();

    // Continuous VGA with a CPU read pending.
    step();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 9'h40;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 9'd5;
    cpu_q.push_back(32'hDEAD_BEEF);
    cpu_at     = -1;
    vga_before = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        step();
        bus.vga_addr = 9'(9'h40 + i);
      end
      #1;
      if (bus.vga_gnt) begin
        vga_q.push_back(pat(bus.vga_addr));
        if (cpu_at < 0) vga_before++;
      end
      if (cpu_slot() && cpu_at < 0) cpu_at = i;
`ifdef VIDEO_ARB_STARVE_GUARD_EN
      if (i == 5) begin
        chk("starve_vga_resume", 32'(bus.vga_gnt), 32'h1);
        chk("starve_ack", 32'(bus.wb_ack_o), 32'h1);
      end
`endif
      if (bus.wb_ack_o) cpu_idle();
    end
`ifdef VIDEO_ARB_STARVE_GUARD_EN
    chk("starve_cpu_slot", 32'(cpu_at), 32'd4);
    chk("starve_vga_before", 32'(vga_before), 32'd4);
    step();
    bus.vga_req = 1'b0;
`else
    chk("strict_no_cpu", 32'(cpu_at), 32'hFFFF_FFFF);
    chk("strict_vga_grants", 32'(vga_before), 32'd10);
    step();
    bus.vga_req = 1'b0;
    #1;
    chk("strict_cpu_gnt", 32'(cpu_slot()), 32'h1);
    step();
    #1;
    chk("strict_ack", 32'(bus.wb_ack_o), 32'h1);
    cpu_idle();
`endif

    // Reset lands before the edge that would register the ack.
    step();
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = 9'd9;
    bus.wb_dat_i = 32'h5555_AAAA;
    #1;
    chk("rstmid_gnt", 32'(cpu_slot()), 32'h1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("rstmid_csb_now", 32'(bus.sram_csb), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rstmid_ack", 32'(bus.wb_ack_o), 32'h0);
      chk("rstmid_csb", 32'(bus.sram_csb), 32'h1);
    end
    step();
    cpu_idle();
    rst_n = 1'b1;

    cpu_access(1'b0, 9'd5, 4'hF, 32'h0, 32'hDEAD_BEEF, "rd5_after_rst");
    cpu_access(1'b0, 9'd9, 4'hF, 32'h0, pat(9'd9), "rd9_unwritten");

    step();
    step();
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("vga_q_drained", 32'(vga_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
